// File: rtl/uart_sched_pkg.sv
// Shared types and the round-robin search used by the UART transmit scheduler
// and other shared-peripheral arbiters.
package uart_sched_pkg;

    typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT_BUSY, WAIT_DONE} sched_state_t;

    localparam int MAX_REQ = 8;

    // Returns {found, index} of the first set request at or after ptr, modulo n.
    function automatic logic [3:0] rr_select(input logic [MAX_REQ-1:0] req,
                                             input logic [2:0] ptr, input int n);
        logic       found;
        logic [2:0] idx;
        logic [2:0] win;
        found = 1'b0;
        idx   = '0;
        win   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                idx = 3'((int'(ptr) + i) % n);
                if (req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return {found, win};
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte streams plus the UART core write/busy handshake.
interface uart_tx_sched_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              uart_wr_o;
    logic [7:0]        uart_dat_o;
    logic              uart_busy_i;

    modport master (output req_valid, req_data, req_last, uart_busy_i,
                    input  req_ready, grant, uart_wr_o, uart_dat_o);
    modport slave  (input  req_valid, req_data, req_last, uart_busy_i,
                    output req_ready, grant, uart_wr_o, uart_dat_o);
endinterface

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin pick: one-hot grant of the first request at or after ptr.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);
    logic [MAX_REQ-1:0] req_w;
    logic [3:0]         sel;

    always_comb begin
        req_w            = '0;
        req_w[NREQ-1:0]  = req;
        sel              = rr_select(req_w, 3'(ptr), NREQ);
        gnt              = sel[3] ? (NREQ'(1) << sel[2:0]) : '0;
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locked scheduler feeding one UART transmit core from NREQ
// byte-stream requesters; strobes each byte once and tracks the core busy flag.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int BUSY_TO = 16,
    parameter int IDLE_TO = 1024
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_sched_if.slave  bus,
    output logic            sched_busy,
    output logic            err_timeout
);
    localparam int PW   = $clog2(NREQ);
    localparam int TMAX = (BUSY_TO > IDLE_TO) ? BUSY_TO : IDLE_TO;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] BUSY_LIM = TW'(BUSY_TO - 1);
    localparam logic [TW-1:0] IDLE_LIM = TW'(IDLE_TO - 1);

    sched_state_t    state, state_n;
    logic [NREQ-1:0] grant_q, grant_n, arb_gnt;
    logic [PW-1:0]   rr_ptr, ptr_n, win_idx;
    logic [TW-1:0]   tmr, tmr_n;
    logic [7:0]      dat_q, dat_n, sel_byte;
    logic            last_q, last_n, err_n;
    logic            sel_valid, sel_last, accept, byte_done;

    rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req_valid), .ptr(rr_ptr), .gnt(arb_gnt));

    always_comb begin
        sel_byte  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                sel_byte  = bus.req_data[8*i +: 8];
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
            end
            if (arb_gnt[i]) win_idx = PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_q     <= '0;
            rr_ptr      <= '0;
            tmr         <= '0;
            dat_q       <= '0;
            last_q      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            grant_q     <= grant_n;
            rr_ptr      <= ptr_n;
            tmr         <= tmr_n;
            dat_q       <= dat_n;
            last_q      <= last_n;
            err_timeout <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant_q;
        ptr_n     = rr_ptr;
        dat_n     = dat_q;
        last_n    = last_q;
        err_n     = err_timeout;
        accept    = 1'b0;
        byte_done = 1'b0;
        tmr_n     = (&tmr) ? tmr : tmr + 1'b1;
        case (state)
            IDLE: begin
                // Holding off on busy lets a byte from before a reset drain first.
                tmr_n = '0;
                if (|bus.req_valid && !bus.uart_busy_i) state_n = ARB;
            end
            ARB: begin
                tmr_n   = '0;
                state_n = IDLE;
                if (|arb_gnt) begin
                    grant_n = arb_gnt;
                    ptr_n   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (sel_valid && !bus.uart_busy_i) begin
                    accept  = 1'b1;
                    dat_n   = sel_byte;
                    last_n  = sel_last;
                    tmr_n   = '0;
                    state_n = WAIT_BUSY;
                end else if (tmr == IDLE_LIM) begin
                    err_n   = 1'b1;
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            WAIT_BUSY: begin
                // A byte the core never picked up is dropped, not retried.
                if (bus.uart_busy_i) begin
                    state_n = WAIT_DONE;
                end else if (tmr == BUSY_LIM) begin
                    err_n     = 1'b1;
                    byte_done = 1'b1;
                end
            end
            WAIT_DONE: if (!bus.uart_busy_i) byte_done = 1'b1;
            default:   state_n = IDLE;
        endcase
        if (byte_done) begin
            if (last_q) begin
                grant_n = '0;
                state_n = IDLE;
            end else begin
                tmr_n   = '0;
                state_n = LOAD;
            end
        end
    end

    assign sched_busy     = (state != IDLE);
    assign bus.grant      = grant_q;
    assign bus.req_ready  = {NREQ{accept}} & grant_q;
    assign bus.uart_wr_o  = accept;
    assign bus.uart_dat_o = accept ? sel_byte : dat_q;
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single UART transmit core among NREQ byte-stream requesters, such as the CPU console path and the energy-measurement streamer.
- A requester keeps the grant for a whole packet, up to the byte flagged last, so frames from different sources never interleave on the line.
- Sequences each byte into the core with a one-cycle write strobe, then tracks the core's busy flag until the byte has left the shifter.
- Sits between the requesters and the uart core, replacing the direct processor write strobe.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BUSY_TO, 16, cycles to wait for uart_busy_i to rise after a strobe before declaring a fault.
- IDLE_TO, 1024, cycles a granted requester may leave req_valid low mid-packet before the grant is revoked.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NREQ  packed request bytes.
- req_last  in  NREQ  byte presented by requester i is the last of its packet.
- req_ready  out  NREQ  one-hot, one-cycle accept pulse; the byte transfers when valid&ready.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- uart_wr_o  out  1  one-cycle write strobe to the uart core.
- uart_dat_o  out  8  byte to the uart core; held stable from the strobe until the byte completes.
- uart_busy_i  in  1  busy flag from the uart core.
- sched_busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky flag: busy never rose within BUSY_TO (set) or grant revoked on IDLE_TO (set); cleared only by rst.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, timers 0. Reset mid-byte abandons the byte and drops grant in the same cycle; no further strobe is issued.
- IDLE:
  - If any req_valid is set, go to ARB. Nothing is accepted in IDLE.
  - Also wait here until uart_busy_i=0 before granting, so a byte left from before reset completes first.
- ARB (1 cycle):
  - Pick the first valid requester starting at rr_ptr, wrapping modulo NREQ.
  - Set grant one-hot and set rr_ptr = winner+1 (wraps to 0 after NREQ-1). Go to LOAD.
- LOAD:
  - If req_valid[g]: pulse req_ready[g], capture the byte into uart_dat_o, record last_q = req_last[g], pulse uart_wr_o in the same cycle, clear the timer, go to WAIT_BUSY.
  - Otherwise count the idle timer. When it reaches IDLE_TO, set err_timeout, clear grant, go to IDLE.
- WAIT_BUSY:
  - When uart_busy_i=1, go to WAIT_DONE.
  - If the timer reaches BUSY_TO first, set err_timeout and continue as if the byte completed. The byte is lost, with no retry.
- WAIT_DONE:
  - On uart_busy_i=0: if last_q, clear grant and go to IDLE. Otherwise clear the timer and go to LOAD with the same grant.
- Latency:
  - Idle to first strobe: 2 cycles after req_valid is seen (IDLE→ARB→LOAD strobe).
  - Busy fall to next strobe within a packet: 1 cycle.
- Exactly one strobe per accepted byte. Strobes never occur while uart_busy_i=1.
- Simultaneous requests are resolved by rr_ptr only; there is no priority input. A requester that deasserts valid mid-packet keeps its grant until IDLE_TO expires.
- A single-byte packet is a byte with req_last=1 at the first accept.
- Timers saturate and are never compared beyond their terminal value. Timer width is clog2(max(BUSY_TO,IDLE_TO))+1.

Decomposition:
- Package uart_sched_pkg: state encoding constants (IDLE, ARB, LOAD, WAIT_BUSY, WAIT_DONE) and the rr-select function.
- One sub-module: rr_arbiter (NREQ, pointer-based first-set search, one-hot output). It is reusable by other shared-peripheral controllers.
- Timers and FSM stay in uart_tx_sched.

Test Plan:
- Single request, NREQ=4, BUSY_TO=16, IDLE_TO=1024:
  - Stimulus: req0 sends bytes 0x41,0x42 (last on 0x42); the core model raises busy 2 cycles after each strobe and holds it for 20 cycles.
  - Required response: two strobes with uart_dat_o=0x41 then 0x42, grant=0001 throughout, grant=0000 after busy falls on byte 2.
- Contention: req1 and req2 both valid from reset with 1-byte packets → req1 served first, then req2, rr_ptr=3. A repeat shows req2 is not served twice in a row ahead of req1.
- Packet lock: req0 sends a 3-byte packet; req3 asserts valid after byte 1 → req3 is granted only after byte 3 (last) completes, with no interleave.
- Busy timeout: the core model never raises busy after a strobe → err_timeout=1 at strobe+16 cycles, grant released after the last byte, err_timeout stays 1.
- Idle revoke: req1 sends byte 0x10 (not last) then drops valid → at 1024 cycles in LOAD, grant=0000 and err_timeout=1; req2 pending is served next.
- Reset mid-byte: rst asserted during WAIT_DONE → next cycle all outputs 0. After rst release with busy still 1, no strobe until busy=0.
